// File: rtl/serial_subtractor16.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock,
// behind a start/done handshake, with borrow, signed-overflow and zero flags.
module serial_subtractor16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             brw, brw_nx, d, last;
  logic             a_msb, b_msb;

  // single full-subtractor cell
  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ brw;
    brw_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    res_nx = {d, res_sr[WIDTH-1:1]};
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= borrow_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_nx;
          brw    <= brw_nx;
          cnt    <= cnt + 1'b1;
          // results are published only with the final bit, so diff never shows partial values
          if (last) begin
            diff       <= res_nx;
            borrow_out <= brw_nx;
            overflow   <= (a_msb != b_msb) & (d != a_msb);
            zero       <= (res_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and randomized self-checking bench for serial_subtractor16 (WIDTH=16).
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        borrow_in;
  logic        busy, done, borrow_out, overflow, zero;
  logic [15:0] diff;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] prev_diff;

  serial_subtractor16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_borrow"}, 32'(borrow_out), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_zero"}, 32'(zero), 32'd0);
  endtask

  // Starts one operation from IDLE and returns at the negedge sample where done is high.
  // Cycle 1 is the first cycle after the start-sampling edge; done is expected in cycle 17.
  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vbin, input logic [15:0] e_diff, input logic e_brw,
                       input logic e_ovf, input logic e_zero, input bit poke);
    int n;
    @(negedge clk);
    a = va; b = vb; borrow_in = vbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~va; b = ~vb; borrow_in = ~vbin;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) break;
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_diff_hold"}, 32'(diff), 32'(prev_diff));
      if (poke && n == 5) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; borrow_in = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd17);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(e_diff));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e_brw));
    check({tag, "_ovf"}, 32'(overflow), 32'(e_ovf));
    check({tag, "_zero"}, 32'(zero), 32'(e_zero));
    prev_diff = e_diff;
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] ra, rb, e_diff;
    logic        rbin, e_ovf;
    int          n;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    prev_diff = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op("sub_5_3",      16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("sub_0_1",      16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("eq_bin0",      16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op("eq_bin1",      16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op("ign_start",    16'h0010, 16'h0005, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b1);

    // the start pulse seen during RUN must not have been queued
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("ign_no_done", 32'(done), 32'd0);
      check("ign_diff_hold", 32'(diff), 32'h000A);
    end
    check("ign_idle_busy", 32'(busy), 32'd0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_diff = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    do_op("after_reset",  16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back regression with start held high: one result every 18 cycles
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 50 == 0) rb = ra;
      a = ra; b = rb; borrow_in = rbin;
      r      = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      e_diff = r[15:0];
      e_ovf  = (ra[15] != rb[15]) && (e_diff[15] != ra[15]);
      for (n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (done) break;
      end
      check("rand_interval", 32'(n), 32'd18);
      check("rand_diff", 32'(diff), 32'(e_diff));
      check("rand_borrow", 32'(borrow_out), 32'(r[16]));
      check("rand_ovf", 32'(overflow), 32'(e_ovf));
      check("rand_zero", 32'(zero), 32'(e_diff == 16'h0000));
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
